// File: rtl/filter_fir_if.sv
// Sample stream bundle for filter_fir: the master (sample source) drives data_in/in_valid,
// and the filter drives pret, out_valid and data_out back.
interface filter_fir_if #(
  parameter int DW = 5
);
  // Valid/ready: a sample transfers on a rising clk edge where in_valid and pret are both high.
  // in_valid while pret is low is dropped. out_valid is a one-cycle strobe with no backpressure.
  logic signed [DW-1:0] data_in;
  logic                 in_valid;
  logic                 pret;
  logic                 out_valid;
  logic signed [DW-1:0] data_out;

  modport master (
    output data_in,
    output in_valid,
    input  pret,
    input  out_valid,
    input  data_out
  );

  modport slave (
    input  data_in,
    input  in_valid,
    output pret,
    output out_valid,
    output data_out
  );
endinterface

// File: rtl/filter_fir.sv
// 8-tap symmetric low-pass FIR (unity DC gain), one IQ channel, 2-cycle latency.
// Build macro FILTER_SATURATE_EN: clamp output to the DW range; if undefined, the output wraps.
module filter_fir #(
  parameter int DW    = 5,
  parameter int CW    = 8,
  parameter int NTAPS = 8
) (
  input  logic          clk,
  input  logic          resetn,
  filter_fir_if.slave   bus,
  output logic          state_dbg
);

  localparam int AW = DW + CW + 3;

  localparam logic signed [CW-1:0] COEF [NTAPS] = '{
    -8'sd3, 8'sd0, 8'sd19, 8'sd48, 8'sd48, 8'sd19, 8'sd0, -8'sd3
  };

  localparam logic signed [AW-1:0] ROUND_HALF = AW'(1 << (CW - 2));
  localparam logic signed [AW-1:0] OUT_MAX    = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] OUT_MIN    = -AW'(1 << (DW - 1));

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;

  logic                 accept;
  logic signed [DW-1:0] x [NTAPS];
  logic                 line_v;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] acc_q;
  logic                 acc_v;
  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] r;
  logic signed [DW-1:0] y;

  assign accept    = bus.in_valid & bus.pret;
  assign state_dbg = state;

  // Ready comes up one edge after reset release and never drops again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_HOLD;
      bus.pret <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          state    <= ST_RUN;
          bus.pret <= 1'b1;
        end
        ST_RUN: begin
          state    <= ST_RUN;
          bus.pret <= 1'b1;
        end
        default: begin
          state    <= ST_HOLD;
          bus.pret <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      line_v <= 1'b0;
    end else begin
      line_v <= accept;
      if (accept) begin
        x[0] <= bus.data_in;
        for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
      end
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc_sum = acc_sum + ($signed({{(AW-DW){x[k][DW-1]}}, x[k]}) *
                           $signed({{(AW-CW){COEF[k][CW-1]}}, COEF[k]}));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      acc_v <= 1'b0;
    end else begin
      acc_v <= line_v;
      if (line_v) acc_q <= acc_sum;
    end
  end

  // Round half up, then drop the 7 fractional bits of the coefficients.
  always_comb begin
    rnd = acc_q + ROUND_HALF;
    r   = rnd >>> (CW - 1);
`ifdef FILTER_SATURATE_EN
    if (r > OUT_MAX)      y = OUT_MAX[DW-1:0];
    else if (r < OUT_MIN) y = OUT_MIN[DW-1:0];
    else                  y = r[DW-1:0];
`else
    y = r[DW-1:0];
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      bus.out_valid <= acc_v;
      if (acc_v) bus.data_out <= y;
    end
  end

endmodule

// File: tb/tb_filter_fir.sv
// Self-checking bench for filter_fir: convolution reference model plus literal spot checks.
module tb_filter_fir;

  localparam int DW = 5;

  logic clk;
  logic resetn;
  logic state_dbg;

  filter_fir_if #(.DW(DW)) bus ();

  filter_fir #(.DW(DW), .CW(8), .NTAPS(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int                 h [8] = '{-3, 0, 19, 48, 48, 19, 0, -3};
  int                 hist [8];
  logic [DW-1:0]      exp_q [$];
  logic [1:0]         dly;
  logic               exp_ov;
  logic               exp_pret;
  logic [DW-1:0]      exp_data;
  logic               accept;

  function automatic logic [DW-1:0] ref_out();
    int acc;
    int r;
    logic [31:0] rv;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += h[k] * hist[k];
    r = (acc + 64) >>> 7;
`ifdef FILTER_SATURATE_EN
    if (r > 15) r = 15;
    if (r < -16) r = -16;
`endif
    rv = r;
    return rv[DW-1:0];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 8; k++) hist[k] = 0;
      exp_q.delete();
      dly      = 2'b00;
      exp_ov   = 1'b0;
      exp_pret = 1'b0;
      exp_data = '0;
    end else begin
      accept = bus.in_valid && exp_pret;
      exp_ov = dly[1];
      dly    = {dly[0], accept};
      if (exp_ov) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL model_underflow: expected queue empty when output due, got 0 entries required >=1");
        end else begin
          exp_data = exp_q.pop_front();
        end
      end
      if (accept) begin
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(bus.data_in);
        exp_q.push_back(ref_out());
      end
      exp_pret = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic signed [DW-1:0] got_q [$];

  always @(negedge clk) begin
    checks++;
    if (bus.pret !== exp_pret) begin
      errors++;
      $display("FAIL pret: got %b required %b at %0t", bus.pret, exp_pret, $time);
    end
    checks++;
    if (bus.out_valid !== exp_ov) begin
      errors++;
      $display("FAIL out_valid: got %b required %b at %0t", bus.out_valid, exp_ov, $time);
    end
    checks++;
    if (bus.data_out !== exp_data) begin
      errors++;
      $display("FAIL data_out: got %0d required %0d at %0t",
               $signed(bus.data_out), $signed(exp_data), $time);
    end
    if (bus.out_valid === 1'b1) got_q.push_back(bus.data_out);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int sample, input logic valid);
    logic [31:0] s;
    s = sample;
    @(posedge clk);
    #1;
    bus.data_in  = s[DW-1:0];
    bus.in_valid = valid;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 1'b0);
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_list(input string name, input int req [$]);
    check_val({name, "_count"}, got_q.size(), req.size());
    for (int i = 0; i < req.size() && i < got_q.size(); i++)
      check_val($sformatf("%s[%0d]", name, i), int'(got_q[i]), req[i]);
  endtask

  // ---------------- stimulus ----------------
  int sat_req;
  int ramp;

  initial begin
    bus.data_in  = '0;
    bus.in_valid = 1'b0;
    resetn       = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_val("reset_pret", int'(bus.pret), 0);
    check_val("reset_out_valid", int'(bus.out_valid), 0);
    check_val("reset_data_out", int'($signed(bus.data_out)), 0);
    resetn = 1'b1;
    // Valid on the edge where ready is still low must be ignored.
    bus.data_in  = 5'sd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_val("pret_after_release", int'(bus.pret), 1);
    idle(4);

    // Impulse response
    got_q.delete();
    send(15, 1'b1);
    for (int i = 0; i < 8; i++) send(0, 1'b1);
    idle(4);
    check_list("impulse", '{0, 0, 2, 6, 6, 2, 0, 0, 0});

    // DC steps
    got_q.delete();
    for (int i = 0; i < 12; i++) send(10, 1'b1);
    idle(4);
    for (int i = 7; i < 12 && i < got_q.size(); i++)
      check_val($sformatf("dc_pos[%0d]", i), int'(got_q[i]), 10);
    check_val("dc_pos_count", got_q.size(), 12);

    got_q.delete();
    for (int i = 0; i < 12; i++) send(-16, 1'b1);
    idle(4);
    for (int i = 7; i < 12 && i < got_q.size(); i++)
      check_val($sformatf("dc_neg[%0d]", i), int'(got_q[i]), -16);
    check_val("dc_neg_count", got_q.size(), 12);

    // Output limiting: acc = 2106 -> r = 16
`ifdef FILTER_SATURATE_EN
    sat_req = 15;
`else
    sat_req = -16;
`endif
    got_q.delete();
    send(-16, 1'b1);
    for (int i = 0; i < 6; i++) send(15, 1'b1);
    send(-16, 1'b1);
    idle(4);
    check_val("sat_count", got_q.size(), 8);
    if (got_q.size() == 8) check_val("sat_value", int'(got_q[7]), sat_req);

    // Gapped ramp: 4 valid / 1 idle
    ramp = -16;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 4) send(0, 1'b0);
      else begin
        send(ramp, 1'b1);
        ramp = (ramp == 15) ? -16 : ramp + 1;
      end
    end
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++)
      send(int'($urandom_range(0, 31)) - 16, $urandom_range(0, 3) != 0);
    idle(4);

    // Reset mid-stream
    for (int i = 0; i < 12; i++) send(10, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check_val("midrst_out_valid", int'(bus.out_valid), 0);
    check_val("midrst_data_out", int'($signed(bus.data_out)), 0);
    check_val("midrst_pret", int'(bus.pret), 0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(1);
    got_q.delete();
    for (int i = 0; i < 10; i++) send(0, 1'b1);
    idle(4);
    check_list("post_reset_zero", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
